// File: rtl/qmc_pkg.sv
// Shared constants, FSM state type and Sobol direction-number generation for the QMC point sequencer.
package qmc_pkg;

   localparam int M_DEF = 12;
   localparam int W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      PRESENT = 2'd2,
      FINISH  = 2'd3
   } state_t;

   function automatic int dim_bits(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // Joe-Kuo primitive polynomials (degree s, coefficients a, initial m values) for dims 1..11.
   // Dimension 0, and any dimension beyond the table, use the van der Corput sequence.
   function automatic logic [63:0] dir_num(input int d, input int k, input int w);
      int s;
      int a;
      int m [5];
      logic [63:0] v [64];
      s = 0;
      a = 0;
      m = '{1, 1, 1, 1, 1};
      case (d)
         1:  begin s = 1; a = 0;  m = '{1, 1, 1, 1, 1};   end
         2:  begin s = 2; a = 1;  m = '{1, 3, 1, 1, 1};   end
         3:  begin s = 3; a = 1;  m = '{1, 3, 1, 1, 1};   end
         4:  begin s = 3; a = 2;  m = '{1, 1, 1, 1, 1};   end
         5:  begin s = 4; a = 1;  m = '{1, 1, 3, 3, 1};   end
         6:  begin s = 4; a = 4;  m = '{1, 3, 5, 13, 1};  end
         7:  begin s = 5; a = 2;  m = '{1, 1, 5, 5, 17};  end
         8:  begin s = 5; a = 4;  m = '{1, 1, 5, 5, 5};   end
         9:  begin s = 5; a = 7;  m = '{1, 1, 7, 11, 19}; end
         10: begin s = 5; a = 11; m = '{1, 1, 5, 1, 1};   end
         11: begin s = 5; a = 13; m = '{1, 1, 1, 3, 11};  end
         default: begin s = 0; a = 0; end
      endcase
      for (int i = 0; i < 64; i++) v[i] = '0;
      if (s == 0) begin
         for (int i = 0; i < w; i++) v[i] = 64'd1 << (w - 1 - i);
      end else begin
         for (int i = 0; i < s; i++) v[i] = 64'(m[i]) << (w - 1 - i);
         for (int i = s; i < w; i++) begin
            v[i] = v[i-s] ^ (v[i-s] >> s);
            for (int j = 1; j < s; j++) begin
               if (((a >> (s - 1 - j)) & 1) != 0) v[i] = v[i] ^ v[i-j];
            end
         end
      end
      return v[k];
   endfunction

endpackage

// File: rtl/sobol.sv
// Combinational Sobol coordinate: XOR of the direction numbers of dimension dim selected by
// the Gray code of N.
module sobol
   import qmc_pkg::*;
#(
   parameter int M  = M_DEF,
   parameter int W  = W_DEF,
   parameter int DW = dim_bits(M)
) (
   input  logic [W-1:0]  N,
   input  logic [DW-1:0] dim,
   output logic [W-1:0]  sobol_out
);

   logic [W-1:0] vtab [M][W];
   logic [W-1:0] gray;

   for (genvar d = 0; d < M; d++) begin : g_dim
      for (genvar k = 0; k < W; k++) begin : g_bit
         localparam logic [63:0] V = dir_num(d, k, W);
         assign vtab[d][k] = V[W-1:0];
      end
   end

   assign gray = N ^ (N >> 1);

   always_comb begin
      sobol_out = '0;
      for (int k = 0; k < W; k++) begin
         if (gray[k]) sobol_out = sobol_out ^ vtab[dim][k];
      end
   end

endmodule

// File: rtl/sobol_point_seq.sv
// Streams M-dimensional Sobol points for indices n_start .. n_start+n_count-1, building each
// point one dimension per cycle through a single shared sobol generator.
module sobol_point_seq
   import qmc_pkg::*;
#(
   parameter int M = M_DEF,
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   n_start,
   input  logic [W-1:0]   n_count,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [M*W-1:0] out_point,
   output logic [W-1:0]   out_index,
   output logic           busy,
   output logic           done
);

   localparam int DW = dim_bits(M);

   state_t        state, state_nx;
   logic [DW-1:0] dim;
   logic [DW-1:0] sob_dim;
   logic [W-1:0]  idx;
   logic [W-1:0]  rem;
   logic [W-1:0]  sob_out;
   logic [W-1:0]  pbuf [M];
   logic          last_dim;

   assign last_dim = (dim == DW'(M - 1));
   assign sob_dim  = (state == FILL) ? dim : '0;

   sobol #(.M(M), .W(W), .DW(DW)) u_sobol (
      .N         (idx),
      .dim       (sob_dim),
      .sobol_out (sob_out)
   );

   always_comb begin
      state_nx  = state;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = (n_count != '0) ? FILL : FINISH;
         end
         FILL: begin
            if (last_dim) state_nx = PRESENT;
         end
         PRESENT: begin
            out_valid = 1'b1;
            // rem is decremented on this transfer; 1 means it was the last point.
            if (out_ready) state_nx = (rem != W'(1)) ? FILL : FINISH;
         end
         FINISH: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dim   <= '0;
         idx   <= '0;
         rem   <= '0;
         for (int d = 0; d < M; d++) pbuf[d] <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  idx <= n_start;
                  rem <= n_count;
               end
            end
            FILL: begin
               pbuf[dim] <= sob_out;
               dim       <= last_dim ? '0 : dim + DW'(1);
            end
            PRESENT: begin
               if (out_ready) begin
                  rem <= rem - W'(1);
                  idx <= idx + W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar d = 0; d < M; d++) begin : g_out
      assign out_point[d*W +: W] = pbuf[d];
   end

   assign out_index = idx;

endmodule

// File: tb/tb_sobol_point_seq.sv
// Self-checking bench for sobol_point_seq: table of directed runs, hand-written stall/reset
// sequences and random runs, all compared against a Bratley-Fox style Sobol model.
module tb_sobol_point_seq;

   localparam int M = 12;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [W-1:0]   n_start;
   logic [W-1:0]   n_count;
   logic           out_valid;
   logic           out_ready;
   logic [M*W-1:0] out_point;
   logic [W-1:0]   out_index;
   logic           busy;
   logic           done;

   int errors = 0;
   int checks = 0;

   logic [31:0] dirv [M][32];

   typedef struct {
      logic [31:0] ns;
      logic [31:0] nc;
      int          stall;
      logic [31:0] exp_c0;
   } vec_t;

   vec_t tbl [6];

   always #5 clk = ~clk;

   sobol_point_seq #(.M(M), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n_start   (n_start),
      .n_count   (n_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_point (out_point),
      .out_index (out_index),
      .busy      (busy),
      .done      (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [M*W-1:0] act, input logic [M*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Direction numbers from the Bratley-Fox integer recurrence on m_i, then v_k = m_(k+1) / 2^(k+1).
   task automatic build_dirs();
      int s_tab [M];
      int a_tab [M];
      int m_tab [M][5];
      longint mm [1:32];
      s_tab = '{0, 1, 2, 3, 3, 4, 4, 5, 5, 5, 5, 5};
      a_tab = '{0, 0, 1, 1, 2, 1, 4, 2, 4, 7, 11, 13};
      m_tab = '{'{0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0}, '{1, 3, 0, 0, 0}, '{1, 3, 1, 0, 0},
                '{1, 1, 1, 0, 0}, '{1, 1, 3, 3, 0}, '{1, 3, 5, 13, 0}, '{1, 1, 5, 5, 17},
                '{1, 1, 5, 5, 5}, '{1, 1, 7, 11, 19}, '{1, 1, 5, 1, 1}, '{1, 1, 1, 3, 11}};
      for (int d = 0; d < M; d++) begin
         for (int i = 1; i <= 32; i++) begin
            if (d == 0) mm[i] = 1;
            else if (i <= s_tab[d]) mm[i] = longint'(m_tab[d][i-1]);
            else begin
               mm[i] = mm[i - s_tab[d]] ^ (mm[i - s_tab[d]] << s_tab[d]);
               for (int j = 1; j < s_tab[d]; j++)
                  if (((a_tab[d] >> (s_tab[d] - 1 - j)) & 1) != 0) mm[i] = mm[i] ^ (mm[i-j] << j);
            end
         end
         for (int k = 0; k < 32; k++) dirv[d][k] = 32'(mm[k+1] << (31 - k));
      end
   endtask

   function automatic logic [M*W-1:0] model_point(input logic [31:0] n);
      logic [31:0]    g;
      logic [31:0]    x;
      logic [M*W-1:0] p;
      g = n ^ (n >> 1);
      p = '0;
      for (int d = 0; d < M; d++) begin
         x = '0;
         for (int k = 0; k < 32; k++) if (g[k]) x = x ^ dirv[d][k];
         p[d*W +: W] = x;
      end
      return p;
   endfunction

   task automatic apply_reset();
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run(input logic [31:0] ns, input logic [31:0] nc, input int stall,
                      input logic chk_c0, input logic [31:0] exp_c0);
      logic [31:0]    idx;
      logic [M*W-1:0] snap_p;
      logic [31:0]    snap_i;
      logic           stable;
      logic           r;
      int             cyc;
      int             n;
      n_start = ns;
      n_count = nc;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      n_start = $urandom;
      n_count = $urandom;
      idx     = ns;
      for (int p = 0; p < int'(nc); p++) begin
         cyc = 0;
         while (!out_valid && cyc <= 100) begin
            out_ready = 1'($urandom_range(0, 1));
            start     = (cyc == 2);
            if (cyc == 2) begin
               n_start = $urandom;
               n_count = $urandom_range(1, 5);
            end
            tick();
            cyc++;
         end
         start = 1'b0;
         if (!out_valid) begin
            check("valid_timeout", out_valid, 1'b1);
            apply_reset();
            return;
         end
         check("latency", cyc, M);
         check("index", out_index, idx);
         check("point", out_point, model_point(idx));
         if (chk_c0 && p == 0) check("coord0", out_point[W-1:0], exp_c0);
         snap_p = out_point;
         snap_i = out_index;
         stable = 1'b1;
         n      = 0;
         forever begin
            r = (stall >= 0) ? (n >= stall) : ($urandom_range(0, 1) == 1);
            if (n >= 40) r = 1'b1;
            out_ready = r;
            tick();
            if (r) break;
            if (!out_valid || out_point !== snap_p || out_index !== snap_i) stable = 1'b0;
            n++;
         end
         if (n > 0) check("hold_stable", stable, 1'b1);
         check("xfer_drops_valid", out_valid, 1'b0);
         idx = idx + 32'd1;
      end
      out_ready = 1'b0;
      check("finish_pulse", {busy, done, out_valid}, 3'b110);
      tick();
      check("back_idle", {busy, done}, 2'b00);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic saw;
      tbl[0] = '{ns: 32'h0000_0000, nc: 32'd1, stall: 0,  exp_c0: 32'h0000_0000};
      tbl[1] = '{ns: 32'h0000_0001, nc: 32'd3, stall: 0,  exp_c0: 32'h8000_0000};
      tbl[2] = '{ns: 32'hFFFF_FFFF, nc: 32'd2, stall: 0,  exp_c0: 32'h0000_0001};
      tbl[3] = '{ns: 32'h0000_0000, nc: 32'd0, stall: 0,  exp_c0: 32'h0000_0000};
      tbl[4] = '{ns: 32'h0000_0002, nc: 32'd2, stall: 10, exp_c0: 32'hC000_0000};
      tbl[5] = '{ns: 32'h0000_0003, nc: 32'd1, stall: -1, exp_c0: 32'h4000_0000};
      build_dirs();

      n_start = '0;
      n_count = '0;
      apply_reset();
      check("reset_ctrl", {out_valid, busy, done}, 3'b000);
      check("reset_index", out_index, 32'd0);
      check("reset_point", out_point, '0);
      tick();

      for (int i = 0; i < 6; i++) begin
         run(tbl[i].ns, tbl[i].nc, tbl[i].stall, 1'b1, tbl[i].exp_c0);
         tick();
      end

      // Reset while the second point of a run is being filled.
      n_start   = 32'd5;
      n_count   = 32'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      cyc       = 0;
      while (!out_valid && cyc <= 100) begin
         tick();
         cyc++;
      end
      check("rst_run_valid", out_valid, 1'b1);
      tick();
      tick();
      tick();
      tick();
      check("rst_in_fill", {busy, out_valid}, 2'b10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_ctrl", {out_valid, busy, done}, 3'b000);
      check("rst_index", out_index, 32'd0);
      check("rst_point", out_point, '0);
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done || busy) saw = 1'b1;
         tick();
      end
      check("rst_no_done", saw, 1'b0);
      out_ready = 1'b0;
      run(32'd7, 32'd1, 0, 1'b0, 32'd0);
      tick();

      for (int i = 0; i < 6; i++) begin
         run($urandom, $urandom_range(0, 3), -1, 1'b0, 32'd0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
